ram_arbiter: RTL



---
 rtl/ram_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between two requesters,
// with a bounded lock for back-to-back transfers and one-cycle read return.
module ram_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          We0,
    input  logic          We1,
    input  logic          Lock0,
    input  logic          Lock1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          RValid0,
    output logic          RValid1,
    output logic [DW-1:0] RData0,
    output logic [DW-1:0] RData1,
    output logic          MemWrite,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] WD,
    input  logic [DW-1:0] RD
);

    localparam int SW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] BURST_CAP = SW'(MAX_BURST);

    typedef enum logic [1:0] {
        LAST_NONE = 2'd0,
        LAST_P0   = 2'd1,
        LAST_P1   = 2'd2
    } last_t;

    last_t         last_q, last_d;
    logic          rr_q, rr_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          rv0_p1, rv1_p1;
    logic          hold0, hold1;
    logic          gnt0, gnt1;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= BURST_CAP) ? BURST_CAP : v + SW'(1);
    endfunction

    // Stage p0: combinational grant; a lock only holds while its owner keeps Req high.
    always_comb begin
        hold0 = (last_q == LAST_P0) && Lock0 && Req0 && (streak_q < BURST_CAP);
        hold1 = (last_q == LAST_P1) && Lock1 && Req1 && (streak_q < BURST_CAP);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (!RST) begin
            if (hold0)
                gnt0 = 1'b1;
            else if (hold1)
                gnt1 = 1'b1;
            else if (Req0 && !Req1)
                gnt0 = 1'b1;
            else if (Req1 && !Req0)
                gnt1 = 1'b1;
            else if (Req0 && Req1) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
            end
        end
    end

    always_comb begin
        MemWrite = 1'b0;
        Address  = '0;
        WD       = '0;
        if (gnt0) begin
            MemWrite = We0;
            Address  = Addr0;
            WD       = WData0;
        end else if (gnt1) begin
            MemWrite = We1;
            Address  = Addr1;
            WD       = WData1;
        end
    end

    // Streak only counts grants made while the other port was kept waiting.
    always_comb begin
        last_d   = LAST_NONE;
        rr_d     = rr_q;
        streak_d = '0;
        if (gnt0) begin
            last_d = LAST_P0;
            rr_d   = 1'b1;
            if (Req1)
                streak_d = (last_q == LAST_P0) ? sat_inc(streak_q) : SW'(1);
        end else if (gnt1) begin
            last_d = LAST_P1;
            rr_d   = 1'b0;
            if (Req0)
                streak_d = (last_q == LAST_P1) ? sat_inc(streak_q) : SW'(1);
        end
    end

    // Stage p1: arbitration state and read-valid flags, aligned with RAM read data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q   <= LAST_NONE;
            rr_q     <= 1'b0;
            streak_q <= '0;
            rv0_p1   <= 1'b0;
            rv1_p1   <= 1'b0;
        end else begin
            last_q   <= last_d;
            rr_q     <= rr_d;
            streak_q <= streak_d;
            rv0_p1   <= gnt0 & ~We0;
            rv1_p1   <= gnt1 & ~We1;
        end
    end

    assign Gnt0    = gnt0;
    assign Gnt1    = gnt1;
    assign RValid0 = rv0_p1;
    assign RValid1 = rv1_p1;
    assign RData0  = RD;
    assign RData1  = RD;

endmodule
